shift_add_mult_ctrl: RTL and testbench

- Control and accumulate stage of the sequential shift-and-add multiplier.
- Sits directly downstream of the left shift register that holds the multiplicand: drives that register's load/shift controls and consumes its parallel output.
- Holds the multiplier operand in an internal right-shift register and adds the shifted multiplicand into a 2W accumulator whenever the current multiplier LSB is 1.
- Delivers an unsigned 2W product with a one-cycle done pulse.

---
 rtl/shift_add_mult_ctrl.sv | 110 +++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Control and accumulate stage of a sequential shift-and-add multiplier.
// Drives the upstream multiplicand shift register and accumulates a 2W product.
module shift_add_mult_ctrl #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned WORD        = WORD_LENGTH * 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_LENGTH-1:0] multiplier,
    input  logic [WORD-1:0]        multiplicand_shifted,
    output logic                   sr_load,
    output logic                   sr_shift,
    output logic [WORD-1:0]        product,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CNT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD-1:0]        acc_q, acc_d;
    logic [WORD-1:0]        product_q, product_d;
    logic [WORD_LENGTH-1:0] b_q, b_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sr_load_q, sr_load_d;
    logic                   sr_shift_q, sr_shift_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Next-state and datapath; outputs are decoded from the next state so they
    // register in step with the state they describe.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        product_d = product_q;
        b_d       = b_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_d     = multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                if (b_q[0]) begin
                    acc_d = acc_q + multiplicand_shifted;
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                // Final add folds straight into the published product.
                if (cnt_q == CNT_LAST) begin
                    product_d = acc_d;
                    state_d   = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        sr_load_d  = (state_d == S_LOAD);
        sr_shift_d = (state_d == S_RUN);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            product_q  <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            sr_load_q  <= 1'b0;
            sr_shift_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            product_q  <= product_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            sr_load_q  <= sr_load_d;
            sr_shift_q <= sr_shift_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sr_load  = sr_load_q;
    assign sr_shift = sr_shift_q;
    assign product  = product_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: models the upstream left shift register and
// checks products, latency, strobes and abort/ignore corner cases.
module tb_shift_add_mult_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned W2 = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  multiplier;
    logic [W-1:0]  mcand;
    logic [W2-1:0] sreg;
    logic          sr_load;
    logic          sr_shift;
    logic [W2-1:0] product;
    logic          busy;
    logic          done;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WORD_LENGTH(W), .WORD(W2)) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .multiplier           (multiplier),
        .multiplicand_shifted (sreg),
        .sr_load              (sr_load),
        .sr_shift             (sr_shift),
        .product              (product),
        .busy                 (busy),
        .done                 (done)
    );

    // Upstream left shift register, serial input tied low.
    always @(posedge clk) begin
        if (sr_load)       sreg <= {{(W2-W){1'b0}}, mcand};
        else if (sr_shift) sreg <= sreg << 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Cycle-level invariants: exclusive strobes, product only moves on done or after reset.
    logic [W2-1:0] prev_p;
    logic          rst_last = 1'b1;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("strobe_exclusive", 32'(sr_load & sr_shift), 32'd0);
            if (product !== prev_p && !done && !rst_last)
                chk("product_stable", 32'(product), 32'(prev_p));
        end
        prev_p   = product;
        rst_last = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation with latency and strobe accounting.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] m,
                          input logic [W2-1:0] exp, input string name);
        int done_cyc, loads, shifts, first_s, last_s;
        chk({name, "_idle_before"}, 32'(busy), 32'd0);
        multiplier = a;
        mcand      = m;
        start      = 1'b1;
        tick();
        start    = 1'b0;
        done_cyc = 0; loads = 0; shifts = 0; first_s = 0; last_s = 0;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            if (sr_load) loads++;
            if (sr_shift) begin
                if (first_s == 0) first_s = c;
                last_s = c;
                shifts++;
            end
            if (done) begin
                done_cyc = c;
                chk({name, "_product"}, 32'(product), 32'(exp));
            end
            tick();
        end
        chk({name, "_done_cycle"}, 32'(done_cyc), 32'd10);
        chk({name, "_load_cycles"}, 32'(loads), 32'd1);
        chk({name, "_shift_cycles"}, 32'(shifts), 32'd8);
        chk({name, "_shift_first"}, 32'(first_s), 32'd2);
        chk({name, "_shift_span"}, 32'(last_s - first_s + 1), 32'd8);
        chk({name, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  m;
        logic [W2-1:0] p;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int d1, d2, dones, dcyc;
        bit hold_bad;
        logic [W-1:0] ra, rm;

        tbl[0] = '{a: 8'd13,  m: 8'd11,   p: 16'h008F};
        tbl[1] = '{a: 8'd255, m: 8'd255,  p: 16'hFE01};
        tbl[2] = '{a: 8'd0,   m: 8'hA5,   p: 16'h0000};
        tbl[3] = '{a: 8'd1,   m: 8'd255,  p: 16'h00FF};
        tbl[4] = '{a: 8'd128, m: 8'd128,  p: 16'h4000};
        tbl[5] = '{a: 8'd255, m: 8'd0,    p: 16'h0000};

        reset = 1'b1; start = 1'b0; multiplier = '0; mcand = '0;
        tick(); tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_load", 32'(sr_load), 32'd0);
        chk("reset_shift", 32'(sr_shift), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].m, tbl[i].p, $sformatf("vec%0d", i));
            tick();
        end

        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom_range(0, 255));
            rm = W'($urandom_range(0, 255));
            run_op(ra, rm, W2'(ra) * W2'(rm), $sformatf("rnd%0d", i));
        end

        // Start pulse mid-RUN with a different multiplier must be ignored.
        multiplier = 8'd13; mcand = 8'd11; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        multiplier = 8'd7; start = 1'b1;
        tick();
        start = 1'b0; multiplier = '0;
        dones = 0; dcyc = 0;
        for (int c = 5; c <= 25; c++) begin
            if (done) begin
                dones++;
                if (dcyc == 0) dcyc = c;
                chk("ignore_product", 32'(product), 32'h008F);
            end
            tick();
        end
        chk("ignore_done_count", 32'(dones), 32'd1);
        chk("ignore_done_cycle", 32'(dcyc), 32'd10);

        // Reset during the fifth RUN cycle aborts and clears product.
        multiplier = 8'd13; mcand = 8'd11; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_shift", 32'(sr_shift), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        run_op(8'd6, 8'd7, 16'h002A, "after_abort");

        // Start held high: back-to-back operations.
        multiplier = 8'd3; mcand = 8'd5; start = 1'b1;
        tick();
        d1 = 0; d2 = 0; hold_bad = 1'b0;
        for (int c = 1; c <= 40 && d2 == 0; c++) begin
            if (done) begin
                if (d1 == 0) begin
                    d1 = c;
                    chk("b2b_first", 32'(product), 32'h000F);
                    multiplier = 8'd200; mcand = 8'd2;
                end else begin
                    d2 = c;
                    chk("b2b_second", 32'(product), 32'h0190);
                    start = 1'b0;
                end
            end else if (d1 != 0 && product !== 16'h000F) begin
                hold_bad = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        chk("b2b_first_cycle", 32'(d1), 32'd10);
        chk("b2b_spacing", 32'(d2 - d1), 32'd11);
        chk("b2b_hold", 32'(hold_bad), 32'd0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
